prog_loader: RTL

- SDRAM-side initiator for program loading: reads a length-prefixed program image from SDRAM and streams it as 16-bit frames into the scheduler's frame store.
- Drives the SDRAM address bus and consumes returned data words after a fixed read latency.
- Asserts prog_loading toward the scheduler for the whole transfer.
- Sits between the SDRAM pins and the scheduler frame input in the gpu top level.

---
 rtl/prog_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: fetches a length-prefixed image from SDRAM and streams each
// payload word into the scheduler frame store as one frame write per word.
module prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int MAX_FRAMES = 1024,
  parameter int RD_LAT     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              sdram_ready,
  output logic              sdram_rd,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] data_input,
  output logic              frame_we,
  output logic [9:0]        frame_idx,
  output logic [DATA_W-1:0] frame_data,
  output logic              prog_loading,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // Handshake: a read is issued on a cycle where sdram_rd && sdram_ready; its
  // word is on data_input exactly RD_LAT cycles later, tracked only by the pipe.
  localparam int CNT_W = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_REQ  = 3'd1,
    S_HDR_WAIT = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] iss_addr;
  logic [CNT_W-1:0]  n_len;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_hdr;
  logic              ret_v;
  logic              ret_hdr;
  logic              hdr_ok;
  logic              accept;

  assign ret_v     = pipe_v[RD_LAT-1];
  assign ret_hdr   = pipe_hdr[RD_LAT-1];
  assign hdr_ok    = (data_input != '0) && (int'(data_input) <= MAX_FRAMES);
  assign accept    = sdram_rd && sdram_ready;
  assign dbg_state = state;

  always_comb begin
    state_nx     = state;
    sdram_rd     = 1'b0;
    input_addr   = '0;
    done         = 1'b0;
    prog_loading = (state != S_IDLE) && (state != S_DONE);
    frame_we     = ret_v && !ret_hdr && ((state == S_STREAM) || (state == S_DRAIN));
    frame_idx    = frame_we ? 10'(wr_cnt) : 10'd0;
    frame_data   = frame_we ? data_input : '0;
    case (state)
      S_IDLE:     if (start) state_nx = S_HDR_REQ;
      S_HDR_REQ: begin
        sdram_rd   = 1'b1;
        input_addr = base_q;
        if (sdram_ready) state_nx = S_HDR_WAIT;
      end
      S_HDR_WAIT: if (ret_v && ret_hdr) state_nx = hdr_ok ? S_STREAM : S_DONE;
      S_STREAM: begin
        if (iss_cnt == n_len) begin
          state_nx = S_DRAIN;
        end else begin
          sdram_rd   = 1'b1;
          input_addr = iss_addr;
        end
      end
      S_DRAIN:    if ((pipe_v == '0) && (wr_cnt == n_len)) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      base_q   <= '0;
      iss_addr <= '0;
      n_len    <= '0;
      iss_cnt  <= '0;
      wr_cnt   <= '0;
      pipe_v   <= '0;
      pipe_hdr <= '0;
      error    <= 1'b0;
    end else begin
      state       <= state_nx;
      pipe_v[0]   <= accept;
      pipe_hdr[0] <= accept && (state == S_HDR_REQ);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_hdr[i] <= pipe_hdr[i-1];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            error  <= 1'b0;
          end
        end
        S_HDR_WAIT: begin
          if (ret_v && ret_hdr) begin
            if (!hdr_ok) begin
              error <= 1'b1;
            end else begin
              n_len    <= CNT_W'(data_input);
              iss_addr <= base_q + ADDR_W'(1);
              iss_cnt  <= '0;
              wr_cnt   <= '0;
            end
          end
        end
        S_STREAM: begin
          if (accept) begin
            iss_addr <= iss_addr + ADDR_W'(1);
            iss_cnt  <= iss_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      // Frame writes only occur in STREAM/DRAIN, never in the header states.
      if (frame_we) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

endmodule
